// File: rtl/beehive_udp_msg.sv
// ---------------------------------------------------------------------------
// beehive_udp_msg
// Shared UDP metadata record handed from the manage stage to each engine
// ahead of the message body.
//   udp_info.data_length : body length in bytes (header already stripped)
// ---------------------------------------------------------------------------
package beehive_udp_msg;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] data_length;
    } udp_info;

endpackage

// File: rtl/beehive_vr_pkg.sv
// ---------------------------------------------------------------------------
// beehive_vr_pkg
// Layout of the replica setup message body and its acceptance rule.
// The body is big-endian: view (64b), replica index (8b), replica count (8b).
// ---------------------------------------------------------------------------
package beehive_vr_pkg;

    localparam int SETUP_BODY_BYTES = 10;
    localparam int SETUP_VIEW_W     = 64;
    localparam int SETUP_IDX_W      = 8;
    localparam int SETUP_NUM_W      = 8;
    localparam int SETUP_BODY_W     = SETUP_VIEW_W + SETUP_IDX_W + SETUP_NUM_W;

    typedef struct packed {
        logic [SETUP_VIEW_W-1:0] view;
        logic [SETUP_IDX_W-1:0]  idx;
        logic [SETUP_NUM_W-1:0]  num;
    } setup_body;

    // A setup body is usable only if it is complete and names an existing replica.
    function automatic logic setup_body_ok(input logic [15:0] len, input setup_body body);
        return (len >= 16'(SETUP_BODY_BYTES)) && (body.num != 8'd0) && (body.idx < body.num);
    endfunction

endpackage

// File: rtl/setup_eng.sv
// ---------------------------------------------------------------------------
// setup_eng
// Consumes a replica setup message (metadata + body flits), validates the
// first body flit and, if acceptable, installs view / replica index / replica
// count. Rejected messages bump a saturating error counter.
//
// Ports
//   clk, rst                       : clock, synchronous active-high reset
//   manage_setup_msg_val/_pkt_info : metadata in;  setup_manage_msg_rdy out
//   manage_setup_req_val/_req/_last/_padbytes : body flits in;
//                                    setup_manage_req_rdy out
//   setup_cfg_val                  : one-cycle pulse when a config is applied
//   setup_configured               : a valid configuration is held
//   setup_view/_replica_idx/_num_replicas : current configuration
//   setup_bad_cnt                  : rejected message count (saturating)
//   setup_eng_rdy                  : engine idle
// ---------------------------------------------------------------------------
module setup_eng
    import beehive_vr_pkg::*;
    import beehive_udp_msg::*;
#(
    parameter int NOC_DATA_W     = -1,
    parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
    parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES)
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      manage_setup_msg_val,
    input  udp_info                   manage_setup_pkt_info,
    output logic                      setup_manage_msg_rdy,

    input  logic                      manage_setup_req_val,
    input  logic [NOC_DATA_W-1:0]     manage_setup_req,
    input  logic                      manage_setup_req_last,
    input  logic [NOC_PADBYTES_W-1:0] manage_setup_req_padbytes,
    output logic                      setup_manage_req_rdy,

    output logic                      setup_cfg_val,
    output logic                      setup_configured,
    output logic [63:0]               setup_view,
    output logic [7:0]                setup_replica_idx,
    output logic [7:0]                setup_num_replicas,
    output logic [15:0]               setup_bad_cnt,
    output logic                      setup_eng_rdy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        DRAIN = 2'd2,
        APPLY = 2'd3
    } state_e;

    state_e      r_state;
    logic        r_msg_rdy;
    logic        r_req_rdy;
    logic        r_eng_rdy;
    logic        r_cfg_val;
    logic        r_configured;
    logic [63:0] r_view;
    logic [7:0]  r_idx;
    logic [7:0]  r_num;
    logic [15:0] r_bad_cnt;

    // Message capture: not reset, only meaningful between accept and APPLY.
    udp_info     r_pkt_info;
    setup_body   r_body;

    logic        w_msg_hs;
    logic        w_req_hs;
    logic        w_apply_ok;
    setup_body   w_body;
    logic        w_unused_bits;

    // The ready registers are 1 only in the states that may accept.
    assign w_msg_hs   = r_msg_rdy & manage_setup_msg_val;
    assign w_req_hs   = r_req_rdy & manage_setup_req_val;
    assign w_body     = setup_body'(manage_setup_req[NOC_DATA_W-1 -: SETUP_BODY_W]);
    assign w_apply_ok = setup_body_ok(r_pkt_info.data_length, r_body);

    // Only data_length and the top of the first flit matter; the rest is sunk here.
    assign w_unused_bits = ^{manage_setup_req_padbytes, manage_setup_req, r_pkt_info};

    // Capture metadata on accept and the first body flit while in FIRST.
    always_ff @(posedge clk) begin
        if (w_msg_hs) begin
            r_pkt_info <= manage_setup_pkt_info;
        end
        if ((r_state == FIRST) && w_req_hs) begin
            r_body <= w_body;
        end
    end

    // Control FSM with registered handshake/status outputs and config registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_msg_rdy    <= 1'b1;
            r_req_rdy    <= 1'b0;
            r_eng_rdy    <= 1'b1;
            r_cfg_val    <= 1'b0;
            r_configured <= 1'b0;
            r_view       <= 64'd0;
            r_idx        <= 8'd0;
            r_num        <= 8'd0;
            r_bad_cnt    <= 16'd0;
        end else begin
            r_cfg_val <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_msg_hs) begin
                        r_state   <= FIRST;
                        r_msg_rdy <= 1'b0;
                        r_req_rdy <= 1'b1;
                        r_eng_rdy <= 1'b0;
                    end
                end
                FIRST: begin
                    if (w_req_hs) begin
                        if (manage_setup_req_last) begin
                            r_state   <= APPLY;
                            r_req_rdy <= 1'b0;
                        end else begin
                            r_state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_req_hs && manage_setup_req_last) begin
                        r_state   <= APPLY;
                        r_req_rdy <= 1'b0;
                    end
                end
                APPLY: begin
                    r_state   <= IDLE;
                    r_msg_rdy <= 1'b1;
                    r_eng_rdy <= 1'b1;
                    // Lower views are accepted too: an operator may roll back.
                    if (w_apply_ok) begin
                        r_cfg_val    <= 1'b1;
                        r_configured <= 1'b1;
                        r_view       <= r_body.view;
                        r_idx        <= r_body.idx;
                        r_num        <= r_body.num;
                    end else if (r_bad_cnt != 16'hFFFF) begin
                        r_bad_cnt <= r_bad_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_msg_rdy <= 1'b1;
                    r_req_rdy <= 1'b0;
                    r_eng_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign setup_manage_msg_rdy = r_msg_rdy;
    assign setup_manage_req_rdy = r_req_rdy;
    assign setup_eng_rdy        = r_eng_rdy;
    assign setup_cfg_val        = r_cfg_val;
    assign setup_configured     = r_configured;
    assign setup_view           = r_view;
    assign setup_replica_idx    = r_idx;
    assign setup_num_replicas   = r_num;
    assign setup_bad_cnt        = r_bad_cnt;

endmodule

// File: tb/tb_setup_eng.sv
// ---------------------------------------------------------------------------
// tb_setup_eng
// Drives directed and random setup messages into setup_eng and compares its
// configuration outputs against a simple expected-configuration model.
// ---------------------------------------------------------------------------
module tb_setup_eng;
    import beehive_udp_msg::*;

    localparam int W   = 128;
    localparam int PB  = W / 8;
    localparam int PBW = $clog2(PB);

    logic           clk;
    logic           rst;
    logic           msg_val;
    udp_info        pkt_info;
    logic           msg_rdy;
    logic           req_val;
    logic [W-1:0]   req;
    logic           req_last;
    logic [PBW-1:0] req_pad;
    logic           req_rdy;
    logic           cfg_val;
    logic           configured;
    logic [63:0]    view;
    logic [7:0]     ridx;
    logic [7:0]     rnum;
    logic [15:0]    bad_cnt;
    logic           eng_rdy;

    int checks = 0;
    int errors = 0;

    // Expected configuration state
    logic [63:0] m_view;
    logic [7:0]  m_idx;
    logic [7:0]  m_num;
    logic        m_conf;
    logic [15:0] m_bad;

    setup_eng #(.NOC_DATA_W(W)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .manage_setup_msg_val      (msg_val),
        .manage_setup_pkt_info     (pkt_info),
        .setup_manage_msg_rdy      (msg_rdy),
        .manage_setup_req_val      (req_val),
        .manage_setup_req          (req),
        .manage_setup_req_last     (req_last),
        .manage_setup_req_padbytes (req_pad),
        .setup_manage_req_rdy      (req_rdy),
        .setup_cfg_val             (cfg_val),
        .setup_configured          (configured),
        .setup_view                (view),
        .setup_replica_idx         (ridx),
        .setup_num_replicas        (rnum),
        .setup_bad_cnt             (bad_cnt),
        .setup_eng_rdy             (eng_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_info(input logic [15:0] len);
        pkt_info.src_ip      = $urandom;
        pkt_info.dst_ip      = $urandom;
        pkt_info.src_port    = 16'($urandom);
        pkt_info.dst_port    = 16'($urandom);
        pkt_info.data_length = len;
    endtask

    task automatic check_config(input string tag);
        check({tag, "_view"}, view, m_view);
        check({tag, "_idx"}, 64'(ridx), 64'(m_idx));
        check({tag, "_num"}, 64'(rnum), 64'(m_num));
        check({tag, "_conf"}, 64'(configured), 64'(m_conf));
        check({tag, "_bad"}, 64'(bad_cnt), 64'(m_bad));
    endtask

    // Wait (bounded) until the given ready is high at a falling edge.
    task automatic wait_rdy(input bit use_req, input string tag);
        int n;
        n = 0;
        while (((use_req ? req_rdy : msg_rdy) !== 1'b1) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    // Send one message starting at the current falling edge; checks the
    // handshake behaviour, APPLY timing and resulting configuration.
    task automatic send_msg(input logic [63:0] v, input logic [7:0] ix, input logic [7:0] nm,
                            input logic [15:0] len, input int nflits,
                            input bit same_cycle, input bit bubbles);
        logic [63:0] r64a;
        logic [63:0] r64b;
        bit ok;
        r64a = {$urandom, $urandom};
        rand_info(len);
        msg_val = 1'b1;
        if (same_cycle) begin
            req_val  = 1'b1;
            req      = {v, ix, nm, r64a[47:0]};
            req_last = (nflits == 1);
        end
        wait_rdy(1'b0, "msg");
        check("req_rdy_while_idle", 64'(req_rdy), 64'd0);
        @(negedge clk);
        msg_val = 1'b0;
        rand_info(16'($urandom));
        check("cfg_val_pulse_width", 64'(cfg_val), 64'd0);
        check("eng_rdy_busy", 64'(eng_rdy), 64'd0);
        check("msg_rdy_busy", 64'(msg_rdy), 64'd0);
        check("req_rdy_first", 64'(req_rdy), 64'd1);
        for (int i = 0; i < nflits; i++) begin
            if (bubbles && ($urandom_range(0, 1) == 1)) begin
                req_val = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            r64b = {$urandom, $urandom};
            req_val  = 1'b1;
            req      = (i == 0) ? {v, ix, nm, r64a[47:0]} : {r64a, r64b};
            req_last = (i == nflits - 1);
            req_pad  = PBW'($urandom);
            wait_rdy(1'b1, "req");
            @(negedge clk);
        end
        req_val  = 1'b0;
        req_last = 1'b0;
        // One cycle after the last-flit handshake: the APPLY cycle.
        check("apply_cfg_val", 64'(cfg_val), 64'd0);
        check("apply_eng_rdy", 64'(eng_rdy), 64'd0);
        check("apply_rdys", 64'({msg_rdy, req_rdy}), 64'd0);
        ok = (len >= 16'd10) && (nm != 8'd0) && (ix < nm);
        if (ok) begin
            m_view = v;
            m_idx  = ix;
            m_num  = nm;
            m_conf = 1'b1;
        end else if (m_bad != 16'hFFFF) begin
            m_bad = m_bad + 16'd1;
        end
        @(negedge clk);
        check("cfg_val", 64'(cfg_val), 64'(ok));
        check("eng_rdy_idle", 64'(eng_rdy), 64'd1);
        check("msg_rdy_idle", 64'(msg_rdy), 64'd1);
        check_config("cfg");
    endtask

    initial begin
        rst      = 1'b1;
        msg_val  = 1'b0;
        req_val  = 1'b0;
        req      = '0;
        req_last = 1'b0;
        req_pad  = '0;
        rand_info(16'd0);
        m_view = 64'd0; m_idx = 8'd0; m_num = 8'd0; m_conf = 1'b0; m_bad = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_cfg_val", 64'(cfg_val), 64'd0);
        check("rst_msg_rdy", 64'(msg_rdy), 64'd1);
        check("rst_req_rdy", 64'(req_rdy), 64'd0);
        check("rst_eng_rdy", 64'(eng_rdy), 64'd1);
        check_config("rst");
        rst = 1'b0;

        // Basic valid single-flit message
        send_msg(64'd5, 8'd1, 8'd3, 16'd10, 1, 1'b0, 1'b0);
        // Three-flit body with bubbles; only flit 1 is used
        send_msg(64'd7, 8'd0, 8'd2, 16'd30, 3, 1'b0, 1'b1);
        // Invalid: idx == num, num == 0, short length
        send_msg(64'd99, 8'd3, 8'd3, 16'd10, 1, 1'b0, 1'b0);
        send_msg(64'd98, 8'd0, 8'd0, 16'd10, 1, 1'b0, 1'b0);
        send_msg(64'd97, 8'd0, 8'd4, 16'd8, 1, 1'b0, 1'b0);
        // Metadata and first flit presented together
        send_msg(64'd11, 8'd2, 8'd4, 16'd12, 1, 1'b1, 1'b0);
        // Lower view still accepted, back-to-back at minimum spacing
        send_msg(64'd3, 8'd0, 8'd1, 16'd10, 1, 1'b0, 1'b0);
        send_msg(64'hFFFF_FFFF_FFFF_FFFF, 8'd254, 8'd255, 16'd10, 2, 1'b1, 1'b0);

        // Reset while draining abandons the message
        rand_info(16'd10);
        msg_val = 1'b1;
        wait_rdy(1'b0, "rst_msg");
        @(negedge clk);
        msg_val  = 1'b0;
        req_val  = 1'b1;
        req      = {64'd55, 8'd0, 8'd1, 48'd0};
        req_last = 1'b0;
        wait_rdy(1'b1, "rst_req");
        @(negedge clk);
        req      = '1;
        check("drain_eng_rdy", 64'(eng_rdy), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        req_val = 1'b0;
        m_view = 64'd0; m_idx = 8'd0; m_num = 8'd0; m_conf = 1'b0; m_bad = 16'd0;
        check("mid_rst_cfg_val", 64'(cfg_val), 64'd0);
        check("mid_rst_rdys", 64'({msg_rdy, req_rdy, eng_rdy}), 64'b101);
        check_config("mid_rst");
        send_msg(64'd9, 8'd0, 8'd1, 16'd10, 1, 1'b0, 1'b0);

        // Random messages
        for (int k = 0; k < 40; k++) begin
            send_msg({$urandom, $urandom}, 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
                     16'($urandom_range(6, 20)), $urandom_range(1, 3),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Saturation of the reject counter
        force dut.r_bad_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_bad_cnt;
        m_bad = 16'hFFFF;
        send_msg(64'd1, 8'd5, 8'd2, 16'd10, 1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
